fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Holds the PC, reads the instruction ROM, and selects the next PC from sequential, branch or jump sources. Honours hazard stalls and squashes wrong-path fetches on redirect. Detects the halt word and drains the pipeline to a clean halt. Its `Instruction_Out`/`PCPlus4_Out` feed the IF/ID register's inputs; `FLUSH_Out` drives that register's flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IMEM_WORDS`, 256, instruction ROM depth in 32-bit words (power of two)
- `HALT_WORD`, 32'hFFFF_FFFF, encoding that stops fetch
- `DRAIN_CYCLES`, 4, unstalled NOP cycles issued after halt detection before `HALTED`

- `CLOCK  in  1  sole clock; all state updates on posedge`
- `RESET  in  1  asynchronous, active-high; clears all state immediately`
- `STALL  in  1  hazard-unit stall; hold PC`
- `BRANCH_TAKEN  in  1  taken branch resolved in ID`
- `BRANCH_TARGET  in  32  branch target byte address`
- `JUMP  in  1  jump resolved in ID`
- `JUMP_TARGET  in  32  jump target byte address`
- `IMEM_ADDR  out  32  byte address to ROM (= PC)`
- `IMEM_DATA  in  32  combinational ROM read data for IMEM_ADDR`
- `Instruction_Out  out  32  instruction to IF/ID (0 = NOP when squashed)`
- `PCPlus4_Out  out  32  PC + 4 to IF/ID`
- `PC_Out  out  32  current PC`
- `FLUSH_Out  out  1  squash request to IF/ID, high in redirect cycle`
- `HALTED  out  1  fetch stopped, pipeline drained`
- `FAULT  out  1  sticky: misaligned target or out-of-range fetch`
- `FETCH_COUNT  out  32  valid instructions delivered, saturating`

## Operation
- States: RUN, DRAIN, HALT. Reset -> RUN.
- RUN, next-PC priority (highest first): JUMP -> `JUMP_TARGET`; BRANCH_TAKEN -> `BRANCH_TARGET`; STALL -> hold; halt detected -> hold; else PC + 4.
- Redirect (JUMP or BRANCH_TAKEN) overrides STALL. `FLUSH_Out` = redirect, RUN only. `Instruction_Out` = 0 in that cycle.
- Target alignment: low 2 bits forced to 0 when loaded into PC. Nonzero low bits set FAULT.
- Out-of-range fetch: PC >= 4*IMEM_WORDS -> `Instruction_Out` = 0 and FAULT set. The PC still advances normally.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Halt detection: RUN, IMEM_DATA == HALT_WORD, no redirect, STALL low.
  - `Instruction_Out` = 0; PC holds.
  - Drain counter loads DRAIN_CYCLES; state -> DRAIN.
- Halt word during STALL: no transition; detection re-evaluated on the next unstalled cycle.
- DRAIN:
  - `Instruction_Out` = 0; PC holds.
  - Counter decrements on each STALL-low cycle; reaching 0 -> HALT.
  - Redirect inputs ignored; `FLUSH_Out` = 0.
- HALT: as DRAIN, but `HALTED` = 1. Only RESET exits.
- FETCH_COUNT increments when RUN, STALL low, and `Instruction_Out` is a real ROM word (not forced 0). Saturates at 32'hFFFF_FFFF.
- FAULT is sticky until RESET. It does not stop fetch.

## Timing
- `IMEM_ADDR`, `PC_Out`, `PCPlus4_Out` (= PC+4), `Instruction_Out`, `FLUSH_Out` are combinational from PC, state and inputs in the same cycle. IF/ID captures them on the next posedge.
- PC, state, drain counter, FETCH_COUNT, FAULT update on posedge.
- Redirect latency: target appears on `IMEM_ADDR` one cycle after the redirect input. Exactly one wrong-path slot is squashed.
- Halt: `HALTED` rises DRAIN_CYCLES unstalled cycles after the detection edge.
- Reset values, asserted asynchronously:
  - PC = RESET_PC; state RUN; drain counter 0.
  - FETCH_COUNT 0, FAULT 0, HALTED 0.
  - Outputs then follow the RUN-state rules above.
- RESET mid-DRAIN or mid-stall: immediate return to the reset values; fetch resumes at RESET_PC on the first edge after deassertion.

## Test plan
- Sequential fetch: ROM[i] = i+1, release reset -> PC steps 0,4,8,12; `Instruction_Out` 1,2,3,4; FETCH_COUNT = 4 after 4 edges.
- Stall: assert STALL for 3 cycles at PC = 8 -> PC stays 8, `Instruction_Out` = ROM[2] throughout, FETCH_COUNT unchanged; resumes at 12.
- Redirect priority:
  - JUMP (0x40) + BRANCH_TAKEN (0x80) + STALL together -> `FLUSH_Out` = 1, `Instruction_Out` = 0, next PC = 0x40.
  - BRANCH_TARGET 0x82 alone -> PC = 0x80, FAULT = 1.
- Halt: HALT_WORD at ROM[5] -> PC holds at 0x14, `Instruction_Out` = 0. One STALL cycle inside DRAIN -> `HALTED` rises 5 edges after detection. A later JUMP is ignored.
- Out-of-range and wrap:
  - PC reaches 4*IMEM_WORDS -> `Instruction_Out` = 0, FAULT = 1.
  - Jump to 32'hFFFF_FFFC -> next PC = 0.
- Async reset mid-DRAIN, between clock edges -> outputs reset immediately; PC = RESET_PC; HALTED = 0; FETCH_COUNT = 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - bus bundle between the fetch stage and its surroundings
//
// Groups the control inputs (stall, redirects), the instruction ROM port and
// the IF/ID-facing outputs of fetch_unit.
//   master : fetch_unit side (drives PC/ROM address and the IF/ID outputs)
//   slave  : pipeline / ROM side (drives stall, redirects and ROM read data)
interface fetch_unit_if;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        JUMP;
    logic [31:0] JUMP_TARGET;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_DATA;
    logic [31:0] Instruction_Out;
    logic [31:0] PCPlus4_Out;
    logic [31:0] PC_Out;
    logic        FLUSH_Out;
    logic        HALTED;
    logic        FAULT;
    logic [31:0] FETCH_COUNT;

    modport master (
        input  STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET, IMEM_DATA,
        output IMEM_ADDR, Instruction_Out, PCPlus4_Out, PC_Out, FLUSH_Out,
               HALTED, FAULT, FETCH_COUNT
    );

    modport slave (
        output STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET, IMEM_DATA,
        input  IMEM_ADDR, Instruction_Out, PCPlus4_Out, PC_Out, FLUSH_Out,
               HALTED, FAULT, FETCH_COUNT
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, next-PC select, squash, halt drain
//
// Ports:
//   CLOCK  : clock, all state updates on posedge
//   RESET  : asynchronous active-high reset
//   bus    : fetch_unit_if.master
//            in  STALL, BRANCH_TAKEN/BRANCH_TARGET, JUMP/JUMP_TARGET, IMEM_DATA
//            out IMEM_ADDR, PC_Out, PCPlus4_Out, Instruction_Out, FLUSH_Out,
//                HALTED, FAULT, FETCH_COUNT
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 256,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    fetch_unit_if.master  bus
);

    localparam int unsigned CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;
    localparam bit          NO_DRAIN   = (DRAIN_CYCLES == 0);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     fetch_count;
    logic [CW-1:0]   drain_cnt;
    logic            fault;
    logic            halted;

    logic            run;
    logic            redirect;
    logic [31:0]     target_raw;
    logic [31:0]     pc_plus4;
    logic            in_range;
    logic            halt_detect;
    logic            fetch_valid;
    logic            count_en;

    assign run         = (state == RUN);
    // Redirects are only honoured while fetching; DRAIN/HALT ignore them.
    assign redirect    = run && (bus.JUMP || bus.BRANCH_TAKEN);
    assign target_raw  = bus.JUMP ? bus.JUMP_TARGET : bus.BRANCH_TARGET;
    assign pc_plus4    = pc + 32'd4;
    // 33-bit compare so a ROM spanning the whole 4 GiB space stays correct.
    assign in_range    = ({1'b0, pc} < IMEM_BYTES);
    // A halt word seen under stall is not acted on; it is re-examined once
    // the stall lifts.
    assign halt_detect = run && !redirect && !bus.STALL && (bus.IMEM_DATA == HALT_WORD);
    // Real ROM word goes to IF/ID; everything else becomes a NOP (0).
    assign fetch_valid = run && !redirect && !halt_detect && in_range;
    assign count_en    = fetch_valid && !bus.STALL;

    assign bus.IMEM_ADDR       = pc;
    assign bus.PC_Out          = pc;
    assign bus.PCPlus4_Out     = pc_plus4;
    assign bus.Instruction_Out = fetch_valid ? bus.IMEM_DATA : 32'h0;
    assign bus.FLUSH_Out       = redirect;
    assign bus.HALTED          = halted;
    assign bus.FAULT           = fault;
    assign bus.FETCH_COUNT     = fetch_count;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= RUN;
            pc          <= RESET_PC;
            drain_cnt   <= '0;
            fetch_count <= 32'h0;
            fault       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (count_en && (fetch_count != 32'hFFFF_FFFF))
                fetch_count <= fetch_count + 32'd1;

            if ((redirect && (target_raw[1:0] != 2'b00)) || (run && !in_range))
                fault <= 1'b1;

            case (state)
                RUN: begin
                    if (redirect) begin
                        pc <= {target_raw[31:2], 2'b00};
                    end else if (halt_detect) begin
                        drain_cnt <= CW'(DRAIN_CYCLES);
                        state     <= NO_DRAIN ? HALT : DRAIN;
                        halted    <= NO_DRAIN;
                    end else if (!bus.STALL) begin
                        pc <= pc_plus4;
                    end
                end
                DRAIN: begin
                    // Only unstalled cycles count toward draining the pipe.
                    if (!bus.STALL) begin
                        drain_cnt <= drain_cnt - CW'(1);
                        if (drain_cnt == CW'(1)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic CLOCK;
    logic RESET;
    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_WORDS   (256),
        .HALT_WORD    (32'hFFFF_FFFF),
        .DRAIN_CYCLES (4)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic [31:0] rom [0:255];
    assign bus.IMEM_DATA = (bus.IMEM_ADDR < 32'd1024) ? rom[bus.IMEM_ADDR[9:2]] : 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flush;
        logic [31:0] cnt;
        logic        fault;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic flush, input logic [31:0] cnt, input logic fault);
        vec_t v;
        v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.pc = pc; v.instr = instr; v.flush = flush; v.cnt = cnt; v.fault = fault;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.STALL         = 1'b0;
        bus.BRANCH_TAKEN  = 1'b0;
        bus.BRANCH_TARGET = 32'h0;
        bus.JUMP          = 1'b0;
        bus.JUMP_TARGET   = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_p4;
        for (int i = 0; i < 256; i++) rom[i] = 32'(i + 1);
        clear_inputs();

        // Reset state
        RESET = 1'b1;
        #1;
        chk("rst_pc", 0, bus.PC_Out, 32'h0);
        chk("rst_cnt", 0, bus.FETCH_COUNT, 32'h0);
        chk("rst_fault", 0, {31'h0, bus.FAULT}, 32'h0);
        chk("rst_halted", 0, {31'h0, bus.HALTED}, 32'h0);
        do_reset();

        //          stall br bt            jmp jt             pc            instr     fl cnt fault
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h0,        32'd1,    0, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h4,        32'd2,    0, 1, 0);
        vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,         32'h8,        32'd3,    0, 2, 0);
        vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,         32'h8,        32'd3,    0, 2, 0);
        vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,         32'h8,        32'd3,    0, 2, 0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h8,        32'd3,    0, 2, 0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,         32'hC,        32'd4,    0, 3, 0);
        vecs[7]  = mk(1, 1, 32'h80,       1, 32'h40,        32'h10,       32'd0,    1, 4, 0);
        vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,         32'h40,       32'd17,   0, 4, 0);
        vecs[9]  = mk(0, 1, 32'h82,       0, 32'h0,         32'h44,       32'd0,    1, 5, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,         32'h80,       32'd33,   0, 5, 1);
        vecs[11] = mk(0, 0, 32'h0,        1, 32'h3FC,       32'h84,       32'd0,    1, 6, 1);
        vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,         32'h3FC,      32'd256,  0, 6, 1);
        vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,         32'h400,      32'd0,    0, 7, 1);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h404,      32'd0,    1, 7, 1);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,         32'hFFFF_FFFC, 32'd0,   0, 7, 1);
        vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,         32'h0,        32'd1,    0, 7, 1);
        vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,         32'h4,        32'd2,    0, 8, 1);

        for (int i = 0; i < 18; i++) begin
            bus.STALL         = vecs[i].stall;
            bus.BRANCH_TAKEN  = vecs[i].br;
            bus.BRANCH_TARGET = vecs[i].bt;
            bus.JUMP          = vecs[i].jmp;
            bus.JUMP_TARGET   = vecs[i].jt;
            #1;
            exp_p4 = vecs[i].pc + 32'd4;
            chk("pc", i, bus.PC_Out, vecs[i].pc);
            chk("imem_addr", i, bus.IMEM_ADDR, vecs[i].pc);
            chk("pcplus4", i, bus.PCPlus4_Out, exp_p4);
            chk("instr", i, bus.Instruction_Out, vecs[i].instr);
            chk("flush", i, {31'h0, bus.FLUSH_Out}, {31'h0, vecs[i].flush});
            chk("count", i, bus.FETCH_COUNT, vecs[i].cnt);
            chk("fault", i, {31'h0, bus.FAULT}, {31'h0, vecs[i].fault});
            chk("halted", i, {31'h0, bus.HALTED}, 32'h0);
            @(negedge CLOCK);
        end
        clear_inputs();

        // Out-of-range fetch sets FAULT from a clean start
        do_reset();
        bus.JUMP = 1'b1; bus.JUMP_TARGET = 32'h3FC;
        #1;
        chk("oor_fault0", 0, {31'h0, bus.FAULT}, 32'h0);
        chk("oor_flush", 0, {31'h0, bus.FLUSH_Out}, 32'h1);
        @(negedge CLOCK);
        clear_inputs();
        #1;
        chk("oor_pc", 1, bus.PC_Out, 32'h3FC);
        chk("oor_instr", 1, bus.Instruction_Out, 32'd256);
        @(negedge CLOCK); #1;
        chk("oor_pc", 2, bus.PC_Out, 32'h400);
        chk("oor_instr", 2, bus.Instruction_Out, 32'h0);
        chk("oor_fault", 2, {31'h0, bus.FAULT}, 32'h0);
        @(negedge CLOCK); #1;
        chk("oor_pc", 3, bus.PC_Out, 32'h404);
        chk("oor_fault", 3, {31'h0, bus.FAULT}, 32'h1);
        chk("oor_count", 3, bus.FETCH_COUNT, 32'd1);

        // Halt: halt word at ROM[5], one stall inside DRAIN, JUMP ignored
        rom[5] = 32'hFFFF_FFFF;
        do_reset();
        repeat (5) @(negedge CLOCK);
        #1;
        chk("halt_pc", 0, bus.PC_Out, 32'h14);
        chk("halt_instr", 0, bus.Instruction_Out, 32'h0);
        chk("halt_count", 0, bus.FETCH_COUNT, 32'd5);
        @(negedge CLOCK);
        bus.JUMP = 1'b1; bus.JUMP_TARGET = 32'h100;
        #1;
        chk("drain_flush", 1, {31'h0, bus.FLUSH_Out}, 32'h0);
        chk("drain_instr", 1, bus.Instruction_Out, 32'h0);
        chk("drain_halted", 1, {31'h0, bus.HALTED}, 32'h0);
        @(negedge CLOCK);
        clear_inputs();
        bus.STALL = 1'b1;
        #1;
        chk("drain_pc", 2, bus.PC_Out, 32'h14);
        @(negedge CLOCK);
        bus.STALL = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        #1;
        chk("drain_halted", 4, {31'h0, bus.HALTED}, 32'h0);
        @(negedge CLOCK);
        #1;
        chk("halted", 5, {31'h0, bus.HALTED}, 32'h1);
        chk("halted_pc", 5, bus.PC_Out, 32'h14);
        bus.JUMP = 1'b1; bus.JUMP_TARGET = 32'h200;
        bus.BRANCH_TAKEN = 1'b1; bus.BRANCH_TARGET = 32'h300;
        #1;
        chk("halted_flush", 6, {31'h0, bus.FLUSH_Out}, 32'h0);
        @(negedge CLOCK);
        clear_inputs();
        #1;
        chk("halted_pc", 7, bus.PC_Out, 32'h14);
        chk("halted", 7, {31'h0, bus.HALTED}, 32'h1);
        chk("halted_count", 7, bus.FETCH_COUNT, 32'd5);

        // Asynchronous reset in the middle of DRAIN, between clock edges
        do_reset();
        repeat (8) @(negedge CLOCK);
        #1;
        chk("pre_rst_count", 0, bus.FETCH_COUNT, 32'd5);
        chk("pre_rst_pc", 0, bus.PC_Out, 32'h14);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_pc", 1, bus.PC_Out, 32'h0);
        chk("arst_halted", 1, {31'h0, bus.HALTED}, 32'h0);
        chk("arst_count", 1, bus.FETCH_COUNT, 32'h0);
        chk("arst_instr", 1, bus.Instruction_Out, 32'd1);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        #1;
        chk("post_rst_pc", 2, bus.PC_Out, 32'h4);
        chk("post_rst_instr", 2, bus.Instruction_Out, 32'd2);
        chk("post_rst_count", 2, bus.FETCH_COUNT, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
